bp_be_mmio_timer: RTL and testbench
===================================

// Module: bp_be_mmio_timer
// PURPOSE
//  Responder for the BE-issued MMIO timer accesses: serves loads/stores to mtime and mtimecmp
//  at their fixed MMIO addresses, free-runs mtime, raises the machine timer interrupt.
//  Sits on the BE MMIO port next to the D$ miss path; one request in flight, 1-cycle latency.
// PARAMETERS
//  vaddr_width_p     39                 MMIO request address width
//  dword_width_p     64                 data width, also mtime/mtimecmp width
//  mtime_addr_p      39'h6f_ffff_fff0   mtime address (dword aligned)
//  mtimecmp_addr_p   39'h6f_ffff_ffe0   mtimecmp address (dword aligned)
//  timebase_div_p    1                  core cycles per mtime tick; must be >= 1
// PORTS
//  clk_i            in   1    clock
//  reset_i          in   1    synchronous, active-high reset
//  mmio_v_i         in   1    request valid
//  mmio_ready_o     out  1    responder can accept a request this cycle
//  mmio_w_i         in   1    1=store, 0=load
//  mmio_addr_i      in   39   byte address
//  mmio_size_i      in   2    bp_be_mmio_size_e: 2'b10=word, 2'b11=dword; others illegal
//  mmio_data_i      in   64   store data (word stores use [31:0])
//  mmio_resp_v_o    out  1    response valid
//  mmio_resp_yumi_i in   1    response consumed; legal only while mmio_resp_v_o=1
//  mmio_resp_data_o out  64   load data; word loads zero-extended (BE sign-extends); 0 on stores
//  mmio_resp_err_o  out  1    access fault: unmapped addr, misaligned, or illegal size
//  timer_irq_o      out  1    registered (mtime >= mtimecmp), unsigned
// BEHAVIOUR
//  Reset: mtime=0, mtimecmp='1, tick count=0, state=IDLE, mmio_ready_o=0 during reset,
//   mmio_resp_v_o=0, resp data/err=0, timer_irq_o=0. Reset mid-transaction drops the response.
//  FSM: IDLE --(mmio_v_i & mmio_ready_o)--> RESP --(mmio_resp_yumi_i)--> IDLE.
//   mmio_ready_o = (state==IDLE) & ~reset_i; no accept in RESP (no bypass on yumi cycle).
//   Response registered on accept; visible next cycle; data/err held stable until yumi.
//  Decode: dword region = addr[38:3] matches mtime or mtimecmp; word accesses use addr[2]
//   to select [31:0] (0) or [63:32] (1); addr[1:0]!=0, dword with addr[2]=1, size<2'b10,
//   or no match -> err=1, no state update, data=0.
//  Stores: update target on the accept edge; word store writes only selected half.
//  mtime: increments by 1 on each tick; wraps 2^64-1 -> 0. Store to mtime on a tick cycle:
//   store wins, no increment that cycle. Tick = prescaler terminal count (every cycle if div=1).
//  Loads return value as of the accept cycle (pre-increment, pre-store).
//  timer_irq_o: registered compare of post-update mtime/mtimecmp; asserts 1 cycle after
//   the edge where mtime >= mtimecmp becomes true; deasserts 1 cycle after a mtimecmp
//   store raises it above mtime. Level, no ack.
// STRUCTURE
//  bp_be_pkg: existing bp_mmio_mtime_addr_gp/bp_mmio_mtimecmp_addr_gp supply the address
//   defaults; add bp_be_mmio_size_e, bp_be_mmio_req_s {w, addr, size, data},
//   bp_be_mmio_resp_s {data, err}.
//  State enum {e_idle, e_resp} local to the module.
//  Sub-module bp_be_mmio_timer_tick: prescaler counter, emits tick_o one cycle in
//   timebase_div_p, counter cleared on reset; degenerates to tick_o=1 when div=1.
// TESTING
//  1. Reset, idle 10 cycles, div=1: dword load mtime_addr -> resp data 10 (+/-accept offset
//     checked exactly vs model), err=0, resp_v one cycle after accept; timer_irq_o=0.
//  2. Store mtimecmp=0x20, wait: timer_irq_o rises exactly 1 cycle after mtime reaches 0x20;
//     store mtimecmp=0xFFFF -> irq falls next cycle.
//  3. Store mtime=64'hFFFF_FFFF_FFFF_FFFE, load 3 cycles later -> wrapped value 1; store on a
//     tick cycle -> stored value retained, no increment.
//  4. Word store 0xDEADBEEF to mtimecmp_addr+4, word load both halves -> hi=0xDEADBEEF,
//     lo unchanged, zero-extended data.
//  5. Load 39'h6f_ffff_ffd0, load mtime_addr+2, dword at +4 -> err=1, data=0, no state change.
//  6. Hold yumi low 5 cycles -> resp stable, ready_o=0, second mmio_v_i not accepted;
//     reset_i during RESP -> resp_v_o=0 next cycle, mtime=0.

Source files
------------

// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - BE shared types and MMIO timer address map
package bp_be_pkg;

    localparam int bp_vaddr_width_gp = 39;
    localparam int bp_dword_width_gp = 64;

    localparam logic [38:0] bp_mmio_mtime_addr_gp    = 39'h6f_ffff_fff0;
    localparam logic [38:0] bp_mmio_mtimecmp_addr_gp = 39'h6f_ffff_ffe0;

    typedef enum logic [1:0] {
        e_mmio_size_byte  = 2'b00,
        e_mmio_size_half  = 2'b01,
        e_mmio_size_word  = 2'b10,
        e_mmio_size_dword = 2'b11
    } bp_be_mmio_size_e;

    typedef struct packed {
        logic                   w;
        logic [38:0]            addr;
        bp_be_mmio_size_e       size;
        logic [63:0]            data;
    } bp_be_mmio_req_s;

    typedef struct packed {
        logic [63:0]            data;
        logic                   err;
    } bp_be_mmio_resp_s;

    // Replace one 32-bit half of a dword, leaving the other half intact
    function automatic logic [63:0] bp_merge_word(input logic [63:0] old_val,
                                                  input logic [31:0] wdata,
                                                  input logic        hi);
        return hi ? {wdata, old_val[31:0]} : {old_val[63:32], wdata};
    endfunction

endpackage

// File: rtl/bp_be_mmio_timer_tick.sv
// rtl/bp_be_mmio_timer_tick.sv - mtime prescaler, one tick per div_p core cycles
module bp_be_mmio_timer_tick #(
    parameter int div_p = 1
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic tick_o
);

    localparam int cnt_width_lp = (div_p > 1) ? $clog2(div_p) : 1;

    logic [cnt_width_lp-1:0] cnt_r;

    // With div_p=1 the counter never leaves 0, so tick_o is constantly high
    assign tick_o = (cnt_r == cnt_width_lp'(div_p - 1));

    // Free-running modulo-div_p counter
    always_ff @(posedge clk_i) begin
        if (reset_i || tick_o)
            cnt_r <= '0;
        else
            cnt_r <= cnt_r + 1'b1;
    end

endmodule

// File: rtl/bp_be_mmio_timer.sv
// rtl/bp_be_mmio_timer.sv - MMIO mtime/mtimecmp responder with machine timer interrupt
module bp_be_mmio_timer
    import bp_be_pkg::*;
#(
    parameter int                 vaddr_width_p   = bp_vaddr_width_gp,
    parameter int                 dword_width_p   = bp_dword_width_gp,
    parameter logic [38:0]        mtime_addr_p    = bp_mmio_mtime_addr_gp,
    parameter logic [38:0]        mtimecmp_addr_p = bp_mmio_mtimecmp_addr_gp,
    parameter int                 timebase_div_p  = 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     mmio_v_i,
    output logic                     mmio_ready_o,
    input  logic                     mmio_w_i,
    input  logic [vaddr_width_p-1:0] mmio_addr_i,
    input  logic [1:0]               mmio_size_i,
    input  logic [dword_width_p-1:0] mmio_data_i,
    output logic                     mmio_resp_v_o,
    input  logic                     mmio_resp_yumi_i,
    output logic [dword_width_p-1:0] mmio_resp_data_o,
    output logic                     mmio_resp_err_o,
    output logic                     timer_irq_o
);

    typedef enum logic {e_idle, e_resp} state_e;

    state_e           state_r;
    logic [63:0]      mtime_r, mtimecmp_r;
    logic [63:0]      mtime_n, mtimecmp_n;
    bp_be_mmio_resp_s resp_r;
    logic             irq_r;
    logic             tick;

    bp_be_mmio_req_s  req;
    logic             accept;
    logic             hit_mtime, hit_cmp, bad;
    logic             is_dword;
    logic [63:0]      rd_sel, rd_data, wr_val;
    logic             wr_en;

    bp_be_mmio_timer_tick #(.div_p(timebase_div_p)) tick_gen (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .tick_o  (tick)
    );

    assign req = '{w: mmio_w_i, addr: mmio_addr_i,
                   size: bp_be_mmio_size_e'(mmio_size_i), data: mmio_data_i};

    assign mmio_ready_o     = (state_r == e_idle) && !reset_i;
    assign accept           = mmio_v_i && mmio_ready_o;
    assign mmio_resp_v_o    = (state_r == e_resp);
    assign mmio_resp_data_o = resp_r.data;
    assign mmio_resp_err_o  = resp_r.err;
    assign timer_irq_o      = irq_r;

    // Address decode; any fault suppresses both the read data and the write
    always_comb begin
        hit_mtime = (req.addr[38:3] == mtime_addr_p[38:3]);
        hit_cmp   = (req.addr[38:3] == mtimecmp_addr_p[38:3]);
        is_dword  = (req.size == e_mmio_size_dword);
        bad       = !(hit_mtime || hit_cmp)
                 || (req.addr[1:0] != 2'b00)
                 || (is_dword && req.addr[2])
                 || (req.size == e_mmio_size_byte)
                 || (req.size == e_mmio_size_half);
    end

    // Load data mux and next-state of both timer registers; a store to mtime beats the tick
    always_comb begin
        rd_sel  = hit_mtime ? mtime_r : mtimecmp_r;
        rd_data = '0;
        if (!req.w && !bad) begin
            if (is_dword)
                rd_data = rd_sel;
            else
                rd_data = req.addr[2] ? {32'b0, rd_sel[63:32]} : {32'b0, rd_sel[31:0]};
        end
        wr_val     = is_dword ? req.data : bp_merge_word(rd_sel, req.data[31:0], req.addr[2]);
        wr_en      = accept && req.w && !bad;
        mtime_n    = (wr_en && hit_mtime) ? wr_val : (tick ? mtime_r + 64'd1 : mtime_r);
        mtimecmp_n = (wr_en && hit_cmp)   ? wr_val : mtimecmp_r;
    end

    // Request/response handshake, timer registers and the registered interrupt compare
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= e_idle;
            resp_r     <= '0;
            mtime_r    <= '0;
            mtimecmp_r <= '1;
            irq_r      <= 1'b0;
        end else begin
            mtime_r    <= mtime_n;
            mtimecmp_r <= mtimecmp_n;
            irq_r      <= (mtime_r >= mtimecmp_r);
            case (state_r)
                e_idle: if (accept) begin
                    state_r <= e_resp;
                    resp_r  <= '{data: rd_data, err: bad};
                end
                e_resp: if (mmio_resp_yumi_i) begin
                    state_r <= e_idle;
                end
                default: state_r <= e_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_be_mmio_timer.sv
// tb/tb_bp_be_mmio_timer.sv - self-checking bench for bp_be_mmio_timer
module tb_bp_be_mmio_timer;

    localparam logic [38:0] mt_addr = 39'h6f_ffff_fff0;
    localparam logic [38:0] mc_addr = 39'h6f_ffff_ffe0;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        mmio_v_i = 1'b0;
    logic        mmio_w_i = 1'b0;
    logic [38:0] mmio_addr_i = '0;
    logic [1:0]  mmio_size_i = 2'b11;
    logic [63:0] mmio_data_i = '0;
    logic        mmio_resp_yumi_i = 1'b0;
    logic        mmio_ready_o, mmio_resp_v_o, mmio_resp_err_o, timer_irq_o;
    logic [63:0] mmio_resp_data_o;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0] data;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    logic [63:0] m_mtime, m_cmp;
    logic        m_busy, m_irq;

    bp_be_mmio_timer dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .mmio_v_i         (mmio_v_i),
        .mmio_ready_o     (mmio_ready_o),
        .mmio_w_i         (mmio_w_i),
        .mmio_addr_i      (mmio_addr_i),
        .mmio_size_i      (mmio_size_i),
        .mmio_data_i      (mmio_data_i),
        .mmio_resp_v_o    (mmio_resp_v_o),
        .mmio_resp_yumi_i (mmio_resp_yumi_i),
        .mmio_resp_data_o (mmio_resp_data_o),
        .mmio_resp_err_o  (mmio_resp_err_o),
        .timer_irq_o      (timer_irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: div=1, so mtime advances every non-reset cycle
    always @(posedge clk) begin : model
        logic        hm, hc, bad, dw;
        logic [63:0] cur, rd, wv;
        exp_t        e;
        if (reset_i) begin
            m_mtime <= '0;
            m_cmp   <= '1;
            m_busy  <= 1'b0;
            m_irq   <= 1'b0;
            sb_q.delete();
        end else begin
            m_irq   <= (m_mtime >= m_cmp);
            m_mtime <= m_mtime + 64'd1;
            if (m_busy && mmio_resp_yumi_i)
                m_busy <= 1'b0;
            if (!m_busy && mmio_v_i) begin
                m_busy = m_busy;
                hm  = (mmio_addr_i[38:3] == mt_addr[38:3]);
                hc  = (mmio_addr_i[38:3] == mc_addr[38:3]);
                dw  = (mmio_size_i == 2'b11);
                bad = !(hm || hc) || (mmio_addr_i[1:0] != 2'b00) || (dw && mmio_addr_i[2])
                   || (mmio_size_i < 2'b10);
                cur = hm ? m_mtime : m_cmp;
                rd  = dw ? cur : (mmio_addr_i[2] ? (cur >> 32) : (cur & 64'h0000_0000_FFFF_FFFF));
                if (dw)
                    wv = mmio_data_i;
                else if (mmio_addr_i[2])
                    wv = {mmio_data_i[31:0], cur[31:0]};
                else
                    wv = {cur[63:32], mmio_data_i[31:0]};
                e.err  = bad;
                e.data = (bad || mmio_w_i) ? 64'd0 : rd;
                sb_q.push_back(e);
                m_busy <= 1'b1;
                if (mmio_w_i && !bad && hm) m_mtime <= wv;
                if (mmio_w_i && !bad && hc) m_cmp   <= wv;
            end
        end
    end

    // Cycle-by-cycle handshake and interrupt check against the model
    always @(negedge clk) begin
        #2;
        chk("ready", mmio_ready_o, !m_busy && !reset_i);
        chk("resp_v", mmio_resp_v_o, m_busy);
        chk("irq", timer_irq_o, m_irq);
    end

    // One request, response checked against the scoreboard, consumed immediately
    task automatic do_req(input logic w, input logic [38:0] a, input logic [1:0] sz,
                          input logic [63:0] d, output logic [63:0] rdata, output logic rerr);
        exp_t e;
        chk("resp_v_before_accept", mmio_resp_v_o, 1'b0);
        mmio_v_i = 1'b1; mmio_w_i = w; mmio_addr_i = a; mmio_size_i = sz; mmio_data_i = d;
        @(negedge clk);
        mmio_v_i = 1'b0; mmio_w_i = 1'b0;
        chk("resp_v_after_accept", mmio_resp_v_o, 1'b1);
        chk("sb_depth", 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("resp_data", mmio_resp_data_o, e.data);
            chk("resp_err", mmio_resp_err_o, e.err);
        end
        rdata = mmio_resp_data_o;
        rerr  = mmio_resp_err_o;
        mmio_resp_yumi_i = 1'b1;
        @(negedge clk);
        mmio_resp_yumi_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [63:0] rd;
        logic        er;
        logic [63:0] held;
        exp_t        e;
        int          waited;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_ready", mmio_ready_o, 1'b0);
        chk("rst_resp_v", mmio_resp_v_o, 1'b0);
        chk("rst_resp_data", mmio_resp_data_o, 64'd0);
        chk("rst_resp_err", mmio_resp_err_o, 1'b0);
        chk("rst_irq", timer_irq_o, 1'b0);
        reset_i = 1'b0;

        // 1. 10 idle cycles then dword load of mtime
        repeat (10) @(negedge clk);
        do_req(1'b0, mt_addr, 2'b11, 64'd0, rd, er);
        chk("t1_mtime", rd, 64'd10);
        chk("t1_err", er, 1'b0);
        chk("t1_irq", timer_irq_o, 1'b0);

        // 2. mtimecmp=0x20: irq rises, then a higher mtimecmp drops it
        do_req(1'b1, mc_addr, 2'b11, 64'h20, rd, er);
        chk("t2_store_data", rd, 64'd0);
        waited = 0;
        while (timer_irq_o !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("t2_irq_rise_timeout", 64'(waited < 100), 64'd1);
        do_req(1'b0, mt_addr, 2'b11, 64'd0, rd, er);
        chk("t2_mtime_at_irq", rd, 64'h21);
        chk("t2_irq_high", timer_irq_o, 1'b1);
        do_req(1'b1, mc_addr, 2'b11, 64'hFFFF, rd, er);
        chk("t2_irq_fall", timer_irq_o, 1'b0);

        // 3. wrap of mtime, and store beating the tick
        do_req(1'b1, mt_addr, 2'b11, 64'hFFFF_FFFF_FFFF_FFFE, rd, er);
        repeat (2) @(negedge clk);
        do_req(1'b0, mt_addr, 2'b11, 64'd0, rd, er);
        chk("t3_wrap", rd, 64'd1);
        do_req(1'b1, mt_addr, 2'b11, 64'h100, rd, er);
        do_req(1'b0, mt_addr, 2'b11, 64'd0, rd, er);
        chk("t3_store_wins", rd, 64'h101);

        // 4. word store to the upper half of mtimecmp, then word/dword loads
        do_req(1'b1, mc_addr + 39'd4, 2'b10, 64'hCAFE_F00D_DEAD_BEEF, rd, er);
        chk("t4_store_err", er, 1'b0);
        do_req(1'b0, mc_addr + 39'd4, 2'b10, 64'd0, rd, er);
        chk("t4_hi", rd, 64'h0000_0000_DEAD_BEEF);
        do_req(1'b0, mc_addr, 2'b10, 64'd0, rd, er);
        chk("t4_lo", rd, 64'h0000_0000_0000_FFFF);
        do_req(1'b0, mc_addr, 2'b11, 64'd0, rd, er);
        chk("t4_dword", rd, 64'hDEAD_BEEF_0000_FFFF);

        // 5. faults: unmapped, misaligned, dword at +4, illegal size, faulting store
        do_req(1'b0, 39'h6f_ffff_ffd0, 2'b11, 64'd0, rd, er);
        chk("t5_unmapped_err", er, 1'b1);
        chk("t5_unmapped_data", rd, 64'd0);
        do_req(1'b0, mt_addr + 39'd2, 2'b10, 64'd0, rd, er);
        chk("t5_misalign_err", er, 1'b1);
        do_req(1'b0, mt_addr + 39'd4, 2'b11, 64'd0, rd, er);
        chk("t5_dword4_err", er, 1'b1);
        chk("t5_dword4_data", rd, 64'd0);
        do_req(1'b0, mt_addr, 2'b01, 64'd0, rd, er);
        chk("t5_size_err", er, 1'b1);
        do_req(1'b1, mc_addr + 39'd4, 2'b11, 64'h1234, rd, er);
        chk("t5_store_err", er, 1'b1);
        do_req(1'b0, mc_addr, 2'b11, 64'd0, rd, er);
        chk("t5_cmp_unchanged", rd, 64'hDEAD_BEEF_0000_FFFF);

        // 6. backpressure: response held, stray store not accepted
        mmio_v_i = 1'b1; mmio_w_i = 1'b0; mmio_addr_i = mt_addr; mmio_size_i = 2'b11;
        @(negedge clk);
        held = mmio_resp_data_o;
        for (int i = 0; i < 5; i++) begin
            mmio_v_i = 1'b1; mmio_w_i = 1'b1; mmio_addr_i = mt_addr; mmio_data_i = 64'd0;
            chk("t6_hold_v", mmio_resp_v_o, 1'b1);
            chk("t6_hold_data", mmio_resp_data_o, held);
            chk("t6_hold_ready", mmio_ready_o, 1'b0);
            @(negedge clk);
        end
        mmio_v_i = 1'b0; mmio_w_i = 1'b0;
        chk("t6_sb_depth", 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("t6_resp_data", mmio_resp_data_o, e.data);
        end
        mmio_resp_yumi_i = 1'b1;
        @(negedge clk);
        mmio_resp_yumi_i = 1'b0;
        do_req(1'b0, mt_addr, 2'b11, 64'd0, rd, er);
        chk("t6_no_stray_store", 64'(rd > 64'h100), 64'd1);

        // 6b. reset while a response is pending drops it and clears mtime
        mmio_v_i = 1'b1; mmio_w_i = 1'b0; mmio_addr_i = mt_addr; mmio_size_i = 2'b11;
        @(negedge clk);
        mmio_v_i = 1'b0;
        chk("t6_pending", mmio_resp_v_o, 1'b1);
        reset_i = 1'b1;
        @(negedge clk);
        chk("t6_reset_resp_v", mmio_resp_v_o, 1'b0);
        chk("t6_reset_resp_data", mmio_resp_data_o, 64'd0);
        reset_i = 1'b0;
        do_req(1'b0, mt_addr, 2'b11, 64'd0, rd, er);
        chk("t6_mtime_after_reset", rd, 64'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
